power_down_sequencer: RTL and testbench

POWER_DOWN_SEQUENCER -- requirements
Module: power_down_sequencer

---
 rtl/lisp_power_pkg.sv | 15 +
 rtl/sat_counter.sv | 26 ++
 rtl/power_down_sequencer.sv | 130 +++++++++++++
 tb/tb_power_down_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lisp_power_pkg.sv
// Shared types and default timing constants for the LispMachine power-down sequencer.
package lisp_power_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_HALT     = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam int DEFAULT_DEBOUNCE_LEN   = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/power_down_sequencer.sv
// Power-down sequencer: debounces the power switch, halts the core, then removes power.
// Define PWRDN_TIMEOUT_EN to force power-off after TIMEOUT_CYCLES HALT cycles without halt_ack.
module power_down_sequencer
    import lisp_power_pkg::*;
#(
    parameter int DEBOUNCE_LEN   = DEFAULT_DEBOUNCE_LEN,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       power_sw,
    input  logic       halt_ack,
    output logic       core_power,
    output logic       halt_req,
    output logic       shutdown_done,
    output logic       timed_out,
    output logic [2:0] dbg_state_o
);

    localparam int OFF_W = $clog2(DEBOUNCE_LEN + 1);
    // The counter reaches DEBOUNCE_LEN on the edge that samples the last low, so compare one below.
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(DEBOUNCE_LEN - 1);

    state_e           state_q, state_d;
    logic             off_clr, off_inc;
    logic [OFF_W-1:0] off_cnt;
    logic             timeout_hit;
    logic             core_power_q, halt_req_q, shutdown_done_q;

    sat_counter #(.WIDTH(OFF_W)) u_off_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (off_clr),
        .inc_i (off_inc),
        .cnt_o (off_cnt)
    );

`ifdef PWRDN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            timed_out_q;

    sat_counter #(.WIDTH(TO_W)) u_to_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != ST_HALT),
        .inc_i (state_q == ST_HALT),
        .cnt_o (to_cnt)
    );

    assign timeout_hit = (to_cnt == TO_LAST);

    // halt_ack takes priority, so a same-cycle acknowledge never flags a timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timed_out_q <= 1'b0;
        end else if ((state_q == ST_HALT) && !halt_ack && timeout_hit) begin
            timed_out_q <= 1'b1;
        end
    end

    assign timed_out = timed_out_q;
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        off_clr = 1'b0;
        off_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (power_on) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!power_sw) begin
                    state_d = ST_DEBOUNCE;
                    off_inc = 1'b1;
                end else begin
                    off_clr = 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (power_sw) begin
                    state_d = ST_RUN;
                    off_clr = 1'b1;
                end else if (off_cnt == OFF_LAST) begin
                    state_d = ST_HALT;
                    off_clr = 1'b1;
                end else begin
                    off_inc = 1'b1;
                end
            end
            ST_HALT: begin
                if (halt_ack || timeout_hit) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            core_power_q    <= 1'b0;
            halt_req_q      <= 1'b0;
            shutdown_done_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            core_power_q    <= (state_d == ST_RUN) || (state_d == ST_DEBOUNCE) || (state_d == ST_HALT);
            halt_req_q      <= (state_d == ST_HALT);
            shutdown_done_q <= (state_d == ST_DONE);
        end
    end

    assign core_power    = core_power_q;
    assign halt_req      = halt_req_q;
    assign shutdown_done = shutdown_done_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_power_down_sequencer.sv
// Directed bench for power_down_sequencer (DEBOUNCE_LEN=16, TIMEOUT_CYCLES=8).
module tb_power_down_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_DEB  = 3'd2;
    localparam logic [2:0] S_HALT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Expected output vectors, ordered {core_power, halt_req, shutdown_done, timed_out}.
    localparam logic [3:0] O_OFF  = 4'b0000;
    localparam logic [3:0] O_RUN  = 4'b1000;
    localparam logic [3:0] O_HALT = 4'b1100;
    localparam logic [3:0] O_DONE = 4'b0010;
    localparam logic [3:0] O_TOUT = 4'b0011;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_on;
    logic       power_sw;
    logic       halt_ack;
    logic       core_power;
    logic       halt_req;
    logic       shutdown_done;
    logic       timed_out;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    power_down_sequencer #(
        .DEBOUNCE_LEN   (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .power_on      (power_on),
        .power_sw      (power_sw),
        .halt_ack      (halt_ack),
        .core_power    (core_power),
        .halt_req      (halt_req),
        .shutdown_done (shutdown_done),
        .timed_out     (timed_out),
        .dbg_state_o   (dbg_state)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {core_power, halt_req, shutdown_done, timed_out};
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] exp);
        n_checks++;
        assert (dbg_state === exp) else begin
            n_fails++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, dbg_state, exp);
        end
    endtask

    // Pulse reset, power up, then hold the switch low for 16 samples: ends in the first HALT cycle.
    task automatic reach_halt();
        rst = 1'b0;
        #1;
        rst      = 1'b1;
        power_on = 1'b1;
        power_sw = 1'b1;
        halt_ack = 1'b0;
        step(1);
        power_sw = 1'b0;
        step(16);
        check_out("reach_halt", O_HALT);
    endtask

    initial begin
        rst      = 1'b0;
        power_on = 1'b0;
        power_sw = 1'b0;
        halt_ack = 1'b0;
        step(2);
        check_out("reset", O_OFF);
        check_state("reset", S_IDLE);

        rst      = 1'b1;
        power_sw = 1'b1;
        step(1);
        check_out("idle_hold", O_OFF);
        power_on = 1'b1;
        step(1);
        check_out("run_entry", O_RUN);
        check_state("run_entry", S_RUN);

        halt_ack = 1'b1;
        step(1);
        check_out("ack_ignored_run", O_RUN);
        check_state("ack_ignored_run", S_RUN);
        halt_ack = 1'b0;

        power_sw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            check_out("low_15", O_RUN);
        end
        check_state("low_15", S_DEB);
        power_sw = 1'b1;
        step(1);
        check_state("sw_bounce", S_RUN);
        check_out("sw_bounce", O_RUN);

        power_sw = 1'b0;
        step(15);
        check_out("low_15b", O_RUN);
        step(1);
        check_out("halt_entry", O_HALT);
        check_state("halt_entry", S_HALT);

        // Switch back on during HALT must not cancel the shutdown; ack on the 5th HALT cycle.
        power_sw = 1'b1;
        step(4);
        check_out("halt_sw_ignored", O_HALT);
        halt_ack = 1'b1;
        step(1);
        halt_ack = 1'b0;
        check_out("ack_done", O_DONE);
        check_state("ack_done", S_DONE);

        power_on = 1'b1;
        power_sw = 1'b0;
        step(3);
        check_out("done_terminal", O_DONE);
        power_sw = 1'b1;
        halt_ack = 1'b1;
        step(3);
        halt_ack = 1'b0;
        check_out("done_terminal2", O_DONE);

        reach_halt();
        step(2);
        rst = 1'b0;
        #1;
        check_out("async_rst", O_OFF);
        check_state("async_rst", S_IDLE);
        #2;
        rst      = 1'b1;
        power_on = 1'b0;
        step(3);
        check_out("no_power_without_on", O_OFF);
        power_on = 1'b1;
        step(1);
        check_out("repower", O_RUN);

`ifdef PWRDN_TIMEOUT_EN
        reach_halt();
        step(7);
        check_out("before_timeout", O_HALT);
        step(1);
        check_out("timeout_done", O_TOUT);
        check_state("timeout_done", S_DONE);

        reach_halt();
        step(7);
        halt_ack = 1'b1;
        step(1);
        halt_ack = 1'b0;
        check_out("ack_beats_timeout", O_DONE);
`else
        reach_halt();
        step(100);
        check_out("no_timeout", O_HALT);
        check_state("no_timeout", S_HALT);
        halt_ack = 1'b1;
        step(1);
        halt_ack = 1'b0;
        check_out("late_ack", O_DONE);

        reach_halt();
        step(7);
        halt_ack = 1'b1;
        step(1);
        halt_ack = 1'b0;
        check_out("ack_cycle8", O_DONE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
